wasm_mem_ctrl: RTL

WASM_MEM_CTRL -- requirements
Module: wasm_mem_ctrl

---
 rtl/wasm_mem_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wasm_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wasm_mem_ctrl
// Purpose  : WebAssembly linear-memory load/store controller for a word RAM
//            with one-cycle read latency. Define WASM_MEM_BOUNDS_EN to trap
//            accesses that run past MEM_LIMIT.
// Revision : 1.0
// ============================================================================
module wasm_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_LIMIT  = 1 << (ADDR_WIDTH + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [31:0]             ram_din,
    input  logic [31:0]             ram_dout
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    logic [2:0]             r_state;
    logic                   r_write;
    logic [1:0]             r_size;
    logic                   r_signed;
    logic [ADDR_WIDTH+1:0]  r_addr;
    logic [31:0]            r_wdata;
    logic                   r_ram_we;
    logic [31:0]            r_ram_din;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [31:0]            r_rsp_rdata;

    logic                   w_misalign;
    logic                   w_oob;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load;
    logic [31:0]            w_mask;
    logic [31:0]            w_wlane;
    logic [31:0]            w_merge;

    always_comb begin
        case (req_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

`ifdef WASM_MEM_BOUNDS_EN
    logic [2:0]             w_nbytes;
    logic [ADDR_WIDTH+2:0]  w_end;

    always_comb begin
        case (req_size)
            2'd0:    w_nbytes = 3'd1;
            2'd1:    w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    // One extra bit so an access ending exactly at the top of the space cannot wrap.
    assign w_end = {1'b0, req_addr} + {{ADDR_WIDTH{1'b0}}, w_nbytes};
    assign w_oob = 32'(w_end) > $unsigned(MEM_LIMIT);
`else
    logic w_unused_limit;

    assign w_unused_limit = MEM_LIMIT[0];
    assign w_oob          = 1'b0;
`endif

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = ram_dout[7:0];
            2'd1:    w_byte = ram_dout[15:8];
            2'd2:    w_byte = ram_dout[23:16];
            default: w_byte = ram_dout[31:24];
        endcase
        w_half = r_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (r_size)
            2'd0:    w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'd1:    w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_load = ram_dout;
        endcase
    end

    always_comb begin
        case (r_size)
            2'd0: begin
                w_mask  = 32'h0000_00FF << {r_addr[1:0], 3'b000};
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_mask  = 32'h0000_FFFF << {r_addr[1], 4'b0000};
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_mask  = 32'hFFFF_FFFF;
                w_wlane = r_wdata;
            end
        endcase
    end

    assign w_merge = (ram_dout & ~w_mask) | (w_wlane & w_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_ram_we    <= 1'b0;
            r_ram_din   <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_ram_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_misalign || w_oob) begin
                            r_state <= c_ERR;
                        end else if (req_write && (req_size == 2'd2)) begin
                            r_state   <= c_WR;
                            r_ram_we  <= 1'b1;
                            r_ram_din <= req_wdata;
                        end else begin
                            r_state <= c_RD;
                        end
                    end
                end
                c_RD: r_state <= c_DATA;
                c_DATA: begin
                    // Sub-word stores reuse the read path, then merge into the fetched word.
                    if (r_write) begin
                        r_state   <= c_WR;
                        r_ram_we  <= 1'b1;
                        r_ram_din <= w_merge;
                    end else begin
                        r_state     <= c_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load;
                    end
                end
                c_WR: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b1;
                end
                c_ERR: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_we    = r_ram_we;
    assign ram_din   = r_ram_din;
    assign ram_addr  = r_addr[ADDR_WIDTH+1:2];

endmodule
`default_nettype wire
